hilo_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for the 32-bit datapath.

---
 rtl/hilo_muldiv_unit_if.sv | 27 ++
 rtl/hilo_muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - command, MTHI/MTLO and result signals of the HI/LO multiply/divide unit
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] T;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, S, T, hi_we, lo_we, wr_data,
        input  HI, LO, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, S, T, hi_we, lo_we, wr_data,
        output HI, LO, busy, done, div_by_zero
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - radix-2 iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    hilo_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic               dzf_q, dzf_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               op_signed;
    logic               s_neg;
    logic               t_neg;
    logic [WIDTH-1:0]   s_mag;
    logic [WIDTH-1:0]   t_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Both datapaths work on magnitudes; the signs are folded back in during FIX.
    assign op_signed = bus.op[0];
    assign s_neg     = op_signed & bus.S[WIDTH-1];
    assign t_neg     = op_signed & bus.T[WIDTH-1];
    assign s_mag     = s_neg ? WIDTH'(-bus.S) : bus.S;
    assign t_mag     = t_neg ? WIDTH'(-bus.T) : bus.T;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifting left.
    assign div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_rem - {1'b0, b_q};
    assign div_next = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = qneg_q ? (2*WIDTH)'(-acc_q) : acc_q;
    assign quo_fix  = qneg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? WIDTH'(-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        dzf_d   = dzf_q;
        s_d     = s_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.hi_we) begin
                    hi_d = bus.wr_data;
                end
                if (bus.lo_we) begin
                    lo_d = bus.wr_data;
                end
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    div_d   = bus.op[1];
                    qneg_d  = s_neg ^ t_neg;
                    rneg_d  = s_neg;
                    dz_d    = bus.op[1] && (bus.T == '0);
                    dzf_d   = 1'b0;
                    s_d     = bus.S;
                    b_d     = bus.op[1] ? t_mag : s_mag;
                    acc_d   = {{WIDTH{1'b0}}, (bus.op[1] ? s_mag : t_mag)};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (!div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (dz_q) begin
                    // A zero divisor still takes the full latency; the dividend is returned unchanged.
                    hi_d  = s_q;
                    lo_d  = '1;
                    dzf_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            dzf_q   <= 1'b0;
            s_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            dzf_q   <= dzf_d;
            s_q     <= s_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;
    assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.div_by_zero = dzf_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard testbench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];

    hilo_muldiv_unit_if #(.WIDTH(32)) bus_if ();

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t);
        exp_t        e;
        logic [63:0] p;
        longint      a;
        longint      b;
        a    = longint'($signed(s));
        b    = longint'($signed(t));
        e.dz = 1'b0;
        p    = '0;
        case (o)
            2'd0: begin
                p = {32'd0, s} * {32'd0, t};
                {e.hi, e.lo} = p;
            end
            2'd1: begin
                p = a * b;
                {e.hi, e.lo} = p;
            end
            default: begin
                if (t == 32'd0) begin
                    e.hi = s;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else if (o == 2'd2) begin
                    e.lo = s / t;
                    e.hi = s % t;
                end else begin
                    p    = a / b;
                    e.lo = p[31:0];
                    p    = a % b;
                    e.hi = p[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge; start is driven in that cycle (cycle 0).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] s, input logic [31:0] t,
                          input exp_t e, input int poke_at);
        int   n;
        int   busy_bad;
        exp_t got;
        bus_if.start = 1'b1;
        bus_if.op    = o;
        bus_if.S     = s;
        bus_if.T     = t;
        sb_q.push_back(e);
        n        = 0;
        busy_bad = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            bus_if.start   = 1'b0;
            bus_if.hi_we   = 1'b0;
            bus_if.S       = $urandom;
            bus_if.T       = $urandom;
            bus_if.wr_data = $urandom;
            if (n == 1) check_eq({tag, "/dz_clear"}, 64'(bus_if.div_by_zero), 64'd0);
            if (bus_if.done) break;
            if (!bus_if.busy) busy_bad++;
            if (n == poke_at) begin
                bus_if.start   = 1'b1;
                bus_if.op      = ~o;
                bus_if.hi_we   = 1'b1;
                bus_if.wr_data = 32'hDEAD_BEEF;
            end
        end
        check_eq({tag, "/latency"}, 64'(n), 64'd34);
        check_eq({tag, "/busy"}, 64'(busy_bad), 64'd0);
        got = sb_q.pop_front();
        check_eq({tag, "/HI"}, 64'(bus_if.HI), 64'(got.hi));
        check_eq({tag, "/LO"}, 64'(bus_if.LO), 64'(got.lo));
        check_eq({tag, "/dz"}, 64'(bus_if.div_by_zero), 64'(got.dz));
    endtask

    function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dz = dz;
        return e;
    endfunction

    initial begin
        logic [1:0]  ro;
        logic [31:0] rs;
        logic [31:0] rt;
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.op      = 2'd0;
        bus_if.S       = '0;
        bus_if.T       = '0;
        bus_if.hi_we   = 1'b0;
        bus_if.lo_we   = 1'b0;
        bus_if.wr_data = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        check_eq("reset/HI", 64'(bus_if.HI), 64'd0);
        check_eq("reset/LO", 64'(bus_if.LO), 64'd0);
        check_eq("reset/busy", 64'(bus_if.busy), 64'd0);
        check_eq("reset/done", 64'(bus_if.done), 64'd0);
        check_eq("reset/dz", 64'(bus_if.div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0), 0);
        run_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0), 0);
        run_op("mult_min", 2'd1, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0, 1'b0), 0);
        run_op("divu", 2'd2, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0), 0);
        run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), 0);
        run_op("div_wrap", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0), 0);
        run_op("divu_zero", 2'd2, 32'd5, 32'd0, mk(32'd5, 32'hFFFF_FFFF, 1'b1), 0);
        run_op("multu_after_dz", 2'd0, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0), 0);
        run_op("div_zero_neg", 2'd3, 32'hFFFF_FFF7, 32'd0, mk(32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1), 0);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            rs = $urandom;
            rt = (i == 2) ? 32'($urandom_range(1, 9)) : $urandom;
            run_op("random", ro, rs, rt, model(ro, rs, rt), (i == 3) ? 5 : 0);
        end
        run_op("busy_poke", 2'd2, 32'd1000, 32'd33, model(2'd2, 32'd1000, 32'd33), 7);

        @(negedge clk);
        bus_if.lo_we   = 1'b1;
        bus_if.wr_data = 32'h0000_1234;
        @(negedge clk);
        bus_if.lo_we = 1'b0;
        check_eq("mtlo/LO", 64'(bus_if.LO), 64'h1234);
        check_eq("mtlo/HI_kept", 64'(bus_if.HI), 64'(32'd10));

        bus_if.start = 1'b1;
        bus_if.op    = 2'd3;
        bus_if.S     = 32'hFFFF_FF9C;
        bus_if.T     = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus_if.start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check_eq("abort/HI", 64'(bus_if.HI), 64'd0);
        check_eq("abort/LO", 64'(bus_if.LO), 64'd0);
        check_eq("abort/busy", 64'(bus_if.busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("abort/done", 64'(bus_if.done), 64'd0);
        end
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check_eq("abort/no_done", 64'(bus_if.done), 64'd0);
        end
        check_eq("abort/LO_idle", 64'(bus_if.LO), 64'd0);
        run_op("multu_post_reset", 2'd0, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0), 0);

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
